// File: rtl/gcn_pkg.sv
// Shared types and defaults for the GCN argmax feeder path.
// Holds the row-buffer FSM state type and the row container type.
package gcn_pkg;

    localparam int DOT_PROD_WIDTH = 16;
    localparam int WEIGHT_COLS    = 3;
    localparam int FEATURE_ROWS   = 6;

    typedef logic [DOT_PROD_WIDTH-1:0] row_t [0:WEIGHT_COLS-1];

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } rowbuf_state_e;

    // Counter width for 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_buf_bank.sv
// One FEATURE_ROWS x WEIGHT_COLS storage bank: single-element write port and
// a combinational full-row read port. Contents are deliberately not reset.
module row_buf_bank #(
    parameter int DOT_PROD_WIDTH = 16,
    parameter int WEIGHT_COLS    = 3,
    parameter int FEATURE_ROWS   = 6,
    parameter int RW             = 3,
    parameter int CW             = 2
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [RW-1:0]             i_wr_row,
    input  logic [CW-1:0]             i_wr_col,
    input  logic [DOT_PROD_WIDTH-1:0] i_wr_data,
    input  logic [RW-1:0]             i_rd_row,
    output logic [DOT_PROD_WIDTH-1:0] o_rd_row [0:WEIGHT_COLS-1]
);

    logic [DOT_PROD_WIDTH-1:0] r_mem [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_row][i_wr_col] <= i_wr_data;
        end
    end

    assign o_rd_row = r_mem[i_rd_row];

endmodule

// File: rtl/adj_fm_wm_row_buffer.sv
// Collects the ADJ x (FM x WM) product matrix element by element and drains it
// to the argmax stage one row per cycle. Define ROW_BUF_DOUBLE_EN for ping-pong banks.
module adj_fm_wm_row_buffer #(
    parameter int DOT_PROD_WIDTH = gcn_pkg::DOT_PROD_WIDTH,
    parameter int WEIGHT_COLS    = gcn_pkg::WEIGHT_COLS,
    parameter int FEATURE_ROWS   = gcn_pkg::FEATURE_ROWS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DOT_PROD_WIDTH-1:0] in_data,
    output logic [DOT_PROD_WIDTH-1:0] adj_fm_wm_row [0:WEIGHT_COLS-1],
    output logic                      enable_read_calc_save,
    output logic [2:0]                argmax_row_count,
    output logic                      done,
    output logic                      busy
);
    import gcn_pkg::*;

    localparam int RW = cnt_w(FEATURE_ROWS);
    localparam int CW = cnt_w(WEIGHT_COLS);
`ifdef ROW_BUF_DOUBLE_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    rowbuf_state_e             r_state, w_state_nxt;
    logic [RW-1:0]             r_row_cnt, w_rd_idx;
    logic [CW-1:0]             r_col_cnt;
    logic [2:0]                r_drain_row, w_drain_nxt;
    logic                      r_en, w_en_nxt, r_done, w_done_nxt;
    logic                      r_wbank, r_rbank, w_rbank_nxt, w_rd_bank;
    logic                      w_in_ready, w_xfer, w_last_elem, w_xfer_last;
    logic                      w_last_row, w_other_full;
    logic [DOT_PROD_WIDTH-1:0] w_bank_rd  [NB][WEIGHT_COLS];
    logic [DOT_PROD_WIDTH-1:0] w_load_row [WEIGHT_COLS];
    logic [DOT_PROD_WIDTH-1:0] r_out_row  [WEIGHT_COLS];

    assign w_xfer      = in_valid && w_in_ready && !clear;
    assign w_last_elem = (r_row_cnt == RW'(FEATURE_ROWS-1)) && (r_col_cnt == CW'(WEIGHT_COLS-1));
    assign w_xfer_last = w_xfer && w_last_elem;
    assign w_last_row  = (r_state == DRAIN) && (r_drain_row == 3'(FEATURE_ROWS-1));

`ifdef ROW_BUF_DOUBLE_EN
    logic [1:0] r_full;
    assign w_in_ready   = !r_full[r_wbank];
    // The bank completing this very cycle counts as ready to follow the current drain.
    assign w_other_full = r_full[~r_rbank] || (w_xfer_last && (r_wbank != r_rbank));
`else
    assign w_in_ready   = (r_state == FILL);
    assign w_other_full = 1'b0;
`endif

    for (genvar b = 0; b < NB; b++) begin : g_bank
        row_buf_bank #(
            .DOT_PROD_WIDTH(DOT_PROD_WIDTH),
            .WEIGHT_COLS   (WEIGHT_COLS),
            .FEATURE_ROWS  (FEATURE_ROWS),
            .RW            (RW),
            .CW            (CW)
        ) u_bank (
            .clk      (clk),
            .i_we     (w_xfer && (r_wbank == 1'(b))),
            .i_wr_row (r_row_cnt),
            .i_wr_col (r_col_cnt),
            .i_wr_data(in_data),
            .i_rd_row (w_rd_idx),
            .o_rd_row (w_bank_rd[b])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_row;
        w_en_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_rd_idx    = '0;
        w_rd_bank   = r_rbank;
        w_rbank_nxt = r_rbank;
        case (r_state)
            FILL: begin
                if (w_xfer_last) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = '0;
                    w_en_nxt    = 1'b1;
                    w_rd_bank   = r_wbank;
                    w_rbank_nxt = r_wbank;
                end
            end
            DRAIN: begin
                if (!w_last_row) begin
                    w_drain_nxt = r_drain_row + 3'd1;
                    w_en_nxt    = 1'b1;
                    w_rd_idx    = RW'(r_drain_row + 3'd1);
                end else begin
                    w_done_nxt  = 1'b1;
                    w_drain_nxt = '0;
                    if (w_other_full) begin
                        w_en_nxt    = 1'b1;
                        w_rd_bank   = ~r_rbank;
                        w_rbank_nxt = ~r_rbank;
                    end else begin
                        w_state_nxt = FILL;
                    end
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Forward the element being written this cycle if it lands in the row being loaded.
    always_comb begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            w_load_row[c] = w_bank_rd[w_rd_bank][c];
            if (w_xfer && (r_wbank == w_rd_bank) && (r_row_cnt == w_rd_idx) &&
                (r_col_cnt == CW'(c))) begin
                w_load_row[c] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_cnt <= '0;
            r_col_cnt <= '0;
        end else if (clear) begin
            r_row_cnt <= '0;
            r_col_cnt <= '0;
        end else if (w_xfer) begin
            if (r_col_cnt == CW'(WEIGHT_COLS-1)) begin
                r_col_cnt <= '0;
                r_row_cnt <= w_last_elem ? '0 : r_row_cnt + 1'b1;
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= FILL;
            r_drain_row <= '0;
            r_en        <= 1'b0;
            r_done      <= 1'b0;
            r_wbank     <= 1'b0;
            r_rbank     <= 1'b0;
            r_out_row   <= '{default: '0};
`ifdef ROW_BUF_DOUBLE_EN
            r_full      <= '0;
`endif
        end else if (clear) begin
            r_state     <= FILL;
            r_drain_row <= '0;
            r_en        <= 1'b0;
            r_done      <= 1'b0;
            r_wbank     <= 1'b0;
            r_rbank     <= 1'b0;
            r_out_row   <= '{default: '0};
`ifdef ROW_BUF_DOUBLE_EN
            r_full      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_drain_row <= w_drain_nxt;
            r_en        <= w_en_nxt;
            r_done      <= w_done_nxt;
            r_rbank     <= w_rbank_nxt;
            if (w_en_nxt) begin
                r_out_row <= w_load_row;
            end else begin
                r_out_row <= '{default: '0};
            end
`ifdef ROW_BUF_DOUBLE_EN
            if (w_xfer_last) begin
                r_full[r_wbank] <= 1'b1;
                r_wbank         <= ~r_wbank;
            end
            if (w_last_row) begin
                r_full[r_rbank] <= 1'b0;
            end
`endif
        end
    end

    assign in_ready              = w_in_ready;
    assign adj_fm_wm_row         = r_out_row;
    assign enable_read_calc_save = r_en;
    assign argmax_row_count      = r_drain_row;
    assign done                  = r_done;
    assign busy                  = (r_state == DRAIN) || (r_row_cnt != '0) || (r_col_cnt != '0);

endmodule

// File: tb/tb_adj_fm_wm_row_buffer.sv
// Bench for adj_fm_wm_row_buffer: randomized streams checked every cycle against a
// queue-of-matrices reference model (honours ROW_BUF_DOUBLE_EN for bank count).
`timescale 1ns/1ps
module tb_adj_fm_wm_row_buffer;

    localparam int W     = 16;
    localparam int WC    = 3;
    localparam int FR    = 6;
    localparam int ELEMS = WC * FR;
`ifdef ROW_BUF_DOUBLE_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic         clear    = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_ready, en, done, busy;
    logic [2:0]   cnt;
    logic [W-1:0] row [0:WC-1];

    int n_vec = 0;
    int n_err = 0;
    bit run   = 1'b0;

    // Reference model: accepted elements of the matrix being filled, and the
    // elements of complete matrices awaiting or undergoing drain (front first).
    logic [W-1:0] part[$];
    logic [W-1:0] mq[$];
    logic [W-1:0] tmp;
    bit m_show = 1'b0, m_done = 1'b0, m_zero = 1'b1, m_acc = 1'b0, exp_ready;
    int m_drow = 0;

    always #5 clk = ~clk;

    adj_fm_wm_row_buffer dut (
        .clk                  (clk),
        .reset                (reset),
        .clear                (clear),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_data              (in_data),
        .adj_fm_wm_row        (row),
        .enable_read_calc_save(en),
        .argmax_row_count     (cnt),
        .done                 (done),
        .busy                 (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 2))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (run) begin
            if (!reset) begin
                part.delete();
                mq.delete();
                m_show = 1'b0;
                m_done = 1'b0;
                m_zero = 1'b1;
                m_acc  = 1'b0;
                chk("rst_ready", 32'(in_ready), 32'd1);
                chk("rst_en",    32'(en),       32'd0);
                chk("rst_done",  32'(done),     32'd0);
                chk("rst_busy",  32'(busy),     32'd0);
                chk("rst_cnt",   32'(cnt),      32'd0);
                for (int c = 0; c < WC; c++) chk("rst_row", 32'(row[c]), 32'd0);
            end else begin
                exp_ready = (mq.size() / ELEMS) < NB;
                chk("in_ready", 32'(in_ready), 32'(exp_ready));
                chk("enable",   32'(en),       32'(m_show));
                chk("done",     32'(done),     32'(m_done));
                chk("busy",     32'(busy),     32'(m_show || (part.size() != 0)));
                if (m_show) begin
                    chk("row_count", 32'(cnt), 32'(m_drow));
                    for (int c = 0; c < WC; c++) chk("row_data", 32'(row[c]), 32'(mq[m_drow*WC + c]));
                end else if (m_zero) begin
                    chk("flush_cnt", 32'(cnt), 32'd0);
                    for (int c = 0; c < WC; c++) chk("flush_row", 32'(row[c]), 32'd0);
                end
                m_zero = 1'b0;
                m_acc  = 1'b0;
                if (clear) begin
                    part.delete();
                    mq.delete();
                    m_show = 1'b0;
                    m_done = 1'b0;
                    m_zero = 1'b1;
                end else begin
                    if (in_valid && exp_ready) begin
                        m_acc = 1'b1;
                        part.push_back(in_data);
                        if (part.size() == ELEMS) begin
                            foreach (part[i]) mq.push_back(part[i]);
                            part.delete();
                        end
                    end
                    m_done = 1'b0;
                    if (m_show) begin
                        if (m_drow == FR-1) begin
                            m_done = 1'b1;
                            for (int i = 0; i < ELEMS; i++) tmp = mq.pop_front();
                            if (mq.size() != 0) m_drow = 0;
                            else m_show = 1'b0;
                        end else begin
                            m_drow++;
                        end
                    end else if (mq.size() != 0) begin
                        m_show = 1'b1;
                        m_drow = 0;
                    end
                end
            end
        end
    end

    // Offer n elements; base != 0 gives base, base+1, ... otherwise a random 0xFFFF/0/any mix.
    task automatic send(input int n, input bit gapped, input int base, input bit keep);
        int k   = 0;
        int cyc = 0;
        while (k < n && cyc < 4000) begin
            @(posedge clk); #1;
            in_valid = gapped ? (cyc % 2 == 0) : 1'b1;
            in_data  = (base != 0) ? W'(base + k) : pick();
            @(negedge clk); #1;
            if (m_acc) k++;
            cyc++;
        end
        if (k < n) chk("send_timeout", 32'(k), 32'(n));
        if (keep) begin
            @(posedge clk); #1;
            in_data = 16'hDEAD;
            cyc = 0;
            while (!m_done && cyc < 100) begin
                @(negedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((m_show || m_done || mq.size() != 0) && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("drain_finished", 32'(en), 32'd0);
    endtask

    initial begin
        int cyc;
        run      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset    = 1'b1;
        in_valid = 1'b0;

        send(18, 1'b0, 1, 1'b1);
        wait_idle();

        send(18, 1'b1, 0, 1'b0);
        wait_idle();

        send(7, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = pick();
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        send(18, 1'b0, 300, 1'b0);
        wait_idle();

        send(18, 1'b0, 600, 1'b0);
        cyc = 0;
        while (!(m_show && m_drow == 3) && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        chk("row3_before_reset", 32'(cnt), 32'd3);
        #1 reset = 1'b0;
        #1;
        chk("async_en",    32'(en),       32'd0);
        chk("async_cnt",   32'(cnt),      32'd0);
        chk("async_ready", 32'(in_ready), 32'd1);
        chk("async_busy",  32'(busy),     32'd0);
        chk("async_row0",  32'(row[0]),   32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        send(18, 1'b0, 700, 1'b0);
        wait_idle();

        send(36, 1'b0, 1000, 1'b0);
        wait_idle();

        repeat (400) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = pick();
            clear    = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
